// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite command manager.
// States, response codes, tuser bit indices and command field offsets.
package axil_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RESP,
    DRAIN
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int CMD_WR_BIT   = 4;
  localparam int CMD_ADDR_LSB = 0;
  localparam int CMD_DATA_LSB = 32;
  localparam int RSP_TMO_BIT  = 2;
  localparam int WD_W         = 32;

endpackage

// File: rtl/axil_watchdog.sv
// Cycle watchdog: counts enabled cycles since the last clear and pulses
// expire on the TIMEOUT_CYCLES-th one. Ports: clk, rst, clr, en, expire.
module axil_watchdog
  import axil_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam bit ENABLED = (TIMEOUT_CYCLES != 0);
  localparam logic [WD_W-1:0] LIMIT =
    ENABLED ? WD_W'(TIMEOUT_CYCLES - 1) : '0;

  logic [WD_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en)
      cnt <= cnt + 1'b1;
  end

  // The caller leaves the counted states on expiry, so this is one cycle.
  assign expire = ENABLED && en && !clr && (cnt == LIMIT);

endmodule

// File: rtl/axil_cmd_manager.sv
// AXI4-Lite manager driven by an AXIS command stream, one transaction at
// a time, with AXIS responses and a timeout watchdog. Ports: aclk/areset,
// s_axis_cmd_*, m_axis_rsp_*, m_axi_* (AW/W/B/AR/R), busy, timeout_sticky.
module axil_cmd_manager
  import axil_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [2:0]  AXI_PROT       = 3'b000
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [63:0] s_axis_cmd_tdata,
  input  logic [4:0]  s_axis_cmd_tuser,
  input  logic        s_axis_cmd_tvalid,
  output logic        s_axis_cmd_tready,
  output logic [31:0] m_axis_rsp_tdata,
  output logic [2:0]  m_axis_rsp_tuser,
  output logic        m_axis_rsp_tvalid,
  input  logic        m_axis_rsp_tready,
  output logic [31:0] m_axi_awaddr,
  output logic [2:0]  m_axi_awprot,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [31:0] m_axi_araddr,
  output logic [2:0]  m_axi_arprot,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  output logic        busy,
  output logic        timeout_sticky
);

  state_t      state;
  logic        wr;
  logic        pend;
  logic [31:0] addr;
  logic [31:0] data;
  logic [3:0]  strb;

  logic cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic aw_left, w_left, fin;
  logic wd_en, expire, tmo;

  assign cmd_hs  = s_axis_cmd_tvalid & s_axis_cmd_tready;
  assign aw_hs   = m_axi_awvalid & m_axi_awready;
  assign w_hs    = m_axi_wvalid & m_axi_wready;
  assign b_hs    = m_axi_bvalid & m_axi_bready;
  assign ar_hs   = m_axi_arvalid & m_axi_arready;
  assign r_hs    = m_axi_rvalid & m_axi_rready;
  assign aw_left = m_axi_awvalid & ~m_axi_awready;
  assign w_left  = m_axi_wvalid & ~m_axi_wready;
  assign fin     = b_hs | r_hs;

  assign wd_en = (state == WR_ADDR_DATA) || (state == WR_RESP) ||
                 (state == RD_ADDR) || (state == RD_DATA);

  // A completing B/R beats a same-cycle expiry.
  assign tmo = expire &&
               !(state == WR_RESP && b_hs) &&
               !(state == RD_DATA && r_hs);

  axil_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wd (
    .clk    (aclk),
    .rst    (areset),
    .clr    (cmd_hs),
    .en     (wd_en),
    .expire (expire)
  );

  assign m_axi_awaddr = addr;
  assign m_axi_wdata  = data;
  assign m_axi_wstrb  = strb;
  assign m_axi_araddr = addr;
  assign m_axi_awprot = AXI_PROT;
  assign m_axi_arprot = AXI_PROT;
  assign busy         = (state != IDLE);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state             <= IDLE;
      wr                <= 1'b0;
      pend              <= 1'b0;
      addr              <= '0;
      data              <= '0;
      strb              <= '0;
      s_axis_cmd_tready <= 1'b0;
      m_axis_rsp_tdata  <= '0;
      m_axis_rsp_tuser  <= '0;
      m_axis_rsp_tvalid <= 1'b0;
      m_axi_awvalid     <= 1'b0;
      m_axi_wvalid      <= 1'b0;
      m_axi_bready      <= 1'b0;
      m_axi_arvalid     <= 1'b0;
      m_axi_rready      <= 1'b0;
      timeout_sticky    <= 1'b0;
    end else begin
      // AXI channels progress in every state, so a timed-out
      // transaction still completes legally in RESP/DRAIN.
      if (aw_hs) m_axi_awvalid <= 1'b0;
      if (w_hs)  m_axi_wvalid  <= 1'b0;
      if (pend && wr && !aw_left && !w_left && !m_axi_bready)
        m_axi_bready <= 1'b1;
      if (b_hs) begin
        m_axi_bready <= 1'b0;
        pend         <= 1'b0;
      end
      if (ar_hs) begin
        m_axi_arvalid <= 1'b0;
        m_axi_rready  <= 1'b1;
      end
      if (r_hs) begin
        m_axi_rready <= 1'b0;
        pend         <= 1'b0;
      end

      if (tmo) begin
        m_axis_rsp_tdata  <= '0;
        m_axis_rsp_tuser  <= {1'b1, RESP_SLVERR};
        m_axis_rsp_tvalid <= 1'b1;
        timeout_sticky    <= 1'b1;
        state             <= RESP;
      end else begin
        unique case (state)
          IDLE: begin
            if (!s_axis_cmd_tready) begin
              s_axis_cmd_tready <= 1'b1;
            end else if (s_axis_cmd_tvalid) begin
              s_axis_cmd_tready <= 1'b0;
              addr <= s_axis_cmd_tdata[CMD_ADDR_LSB +: 32];
              data <= s_axis_cmd_tdata[CMD_DATA_LSB +: 32];
              strb <= s_axis_cmd_tuser[3:0];
              wr   <= s_axis_cmd_tuser[CMD_WR_BIT];
              pend <= 1'b1;
              if (s_axis_cmd_tuser[CMD_WR_BIT]) begin
                m_axi_awvalid <= 1'b1;
                m_axi_wvalid  <= 1'b1;
                state         <= WR_ADDR_DATA;
              end else begin
                m_axi_arvalid <= 1'b1;
                state         <= RD_ADDR;
              end
            end
          end
          WR_ADDR_DATA: begin
            if (!aw_left && !w_left)
              state <= WR_RESP;
          end
          WR_RESP: begin
            if (b_hs) begin
              m_axis_rsp_tdata  <= '0;
              m_axis_rsp_tuser  <= {1'b0, m_axi_bresp};
              m_axis_rsp_tvalid <= 1'b1;
              state             <= RESP;
            end
          end
          RD_ADDR: begin
            if (ar_hs)
              state <= RD_DATA;
          end
          RD_DATA: begin
            if (r_hs) begin
              m_axis_rsp_tdata  <= m_axi_rdata;
              m_axis_rsp_tuser  <= {1'b0, m_axi_rresp};
              m_axis_rsp_tvalid <= 1'b1;
              state             <= RESP;
            end
          end
          RESP: begin
            if (m_axis_rsp_tready) begin
              m_axis_rsp_tvalid <= 1'b0;
              if (pend && !fin) begin
                state <= DRAIN;
              end else begin
                state             <= IDLE;
                s_axis_cmd_tready <= 1'b1;
              end
            end
          end
          DRAIN: begin
            if (fin || !pend) begin
              state             <= IDLE;
              s_axis_cmd_tready <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axil_cmd_manager.sv
// Directed bench for axil_cmd_manager with a scoreboarded response stream
// and a configurable AXI4-Lite subordinate model.
module tb_axil_cmd_manager;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  user;
  } rsp_t;

  logic        aclk = 1'b0;
  logic        areset;
  logic [63:0] s_axis_cmd_tdata;
  logic [4:0]  s_axis_cmd_tuser;
  logic        s_axis_cmd_tvalid;
  logic        s_axis_cmd_tready;
  logic [31:0] m_axis_rsp_tdata;
  logic [2:0]  m_axis_rsp_tuser;
  logic        m_axis_rsp_tvalid;
  logic        m_axis_rsp_tready;
  logic [31:0] m_axi_awaddr;
  logic [2:0]  m_axi_awprot;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;
  logic        m_axi_bready;
  logic [31:0] m_axi_araddr;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic        busy;
  logic        timeout_sticky;

  axil_cmd_manager #(
    .TIMEOUT_CYCLES(16),
    .AXI_PROT(3'b000)
  ) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_cmd_tdata(s_axis_cmd_tdata),
    .s_axis_cmd_tuser(s_axis_cmd_tuser),
    .s_axis_cmd_tvalid(s_axis_cmd_tvalid),
    .s_axis_cmd_tready(s_axis_cmd_tready),
    .m_axis_rsp_tdata(m_axis_rsp_tdata),
    .m_axis_rsp_tuser(m_axis_rsp_tuser),
    .m_axis_rsp_tvalid(m_axis_rsp_tvalid),
    .m_axis_rsp_tready(m_axis_rsp_tready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .busy(busy), .timeout_sticky(timeout_sticky)
  );

  always #5 aclk = ~aclk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always @(posedge aclk) cyc++;

  rsp_t sb[$];

  // subordinate configuration
  int          aw_delay = 0, w_delay = 0, b_delay = 0;
  int          ar_delay = 0, r_delay = 0;
  logic [31:0] slv_rdata = '0;
  logic [1:0]  slv_rresp = '0;
  logic [1:0]  slv_bresp = '0;

  // subordinate / monitor state
  int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
  int pend_aw = 0, pend_w = 0, b_owed = 0, r_owed = 0;
  int aw_n = 0, w_n = 0, b_n = 0, ar_n = 0, r_n = 0, rsp_n = 0;
  int rsp_rise = 0, rdy_bad = 0, acc_cyc = 0;
  logic        rsp_prev = 1'b0;
  logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;
  logic [3:0]  cap_wstrb = '0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and handshakes are observed on the falling edge.
  always @(negedge aclk) begin
    if (areset) begin
      m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
      m_axi_arready = 0; m_axi_rvalid = 0;
      aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
      pend_aw = 0; pend_w = 0; b_owed = 0; r_owed = 0;
      rsp_prev = 1'b0;
    end else begin
      m_axi_awready = m_axi_awvalid && (aw_wait >= aw_delay);
      if (m_axi_awvalid && !m_axi_awready) aw_wait++;
      else if (!m_axi_awvalid) aw_wait = 0;
      m_axi_wready = m_axi_wvalid && (w_wait >= w_delay);
      if (m_axi_wvalid && !m_axi_wready) w_wait++;
      else if (!m_axi_wvalid) w_wait = 0;
      m_axi_arready = m_axi_arvalid && (ar_wait >= ar_delay);
      if (m_axi_arvalid && !m_axi_arready) ar_wait++;
      else if (!m_axi_arvalid) ar_wait = 0;
      m_axi_bresp = slv_bresp;
      if (b_owed > 0) begin
        if (b_wait >= b_delay) m_axi_bvalid = 1'b1;
        else b_wait++;
      end else begin
        m_axi_bvalid = 1'b0;
        b_wait = 0;
      end
      m_axi_rdata = slv_rdata;
      m_axi_rresp = slv_rresp;
      if (r_owed > 0) begin
        if (r_wait >= r_delay) m_axi_rvalid = 1'b1;
        else r_wait++;
      end else begin
        m_axi_rvalid = 1'b0;
        r_wait = 0;
      end

      if (m_axi_awvalid && m_axi_awready) begin
        aw_n++; pend_aw++; cap_awaddr = m_axi_awaddr;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        w_n++; pend_w++;
        cap_wdata = m_axi_wdata; cap_wstrb = m_axi_wstrb;
      end
      if (pend_aw > 0 && pend_w > 0) begin
        pend_aw--; pend_w--; b_owed++;
      end
      if (m_axi_bvalid && m_axi_bready) begin
        b_n++; b_owed--; b_wait = 0;
      end
      if (m_axi_arvalid && m_axi_arready) begin
        ar_n++; r_owed++; cap_araddr = m_axi_araddr;
      end
      if (m_axi_rvalid && m_axi_rready) begin
        r_n++; r_owed--; r_wait = 0;
      end

      if (m_axis_rsp_tvalid && !rsp_prev) rsp_rise = cyc;
      rsp_prev = m_axis_rsp_tvalid;
      if (m_axis_rsp_tvalid && m_axis_rsp_tready) begin
        rsp_n++;
        if (sb.size() == 0) begin
          check("unexpected_rsp", 64'(sb.size()), 64'd1);
        end else begin
          rsp_t e;
          e = sb.pop_front();
          check("rsp_tdata", 64'(m_axis_rsp_tdata), 64'(e.data));
          check("rsp_tuser", 64'(m_axis_rsp_tuser), 64'(e.user));
        end
      end
      if (s_axis_cmd_tready && busy) rdy_bad++;
    end
  end

  task automatic step();
    @(posedge aclk);
    #2;
  endtask

  task automatic send_cmd(input logic [31:0] a, input logic [31:0] d,
                          input logic w, input logic [3:0] s);
    int i;
    s_axis_cmd_tdata  = {d, a};
    s_axis_cmd_tuser  = {w, s};
    s_axis_cmd_tvalid = 1'b1;
    for (i = 0; i < 100 && !s_axis_cmd_tready; i++) step();
    check("cmd_accept", 64'(s_axis_cmd_tready), 64'd1);
    acc_cyc = cyc;
    step();
    s_axis_cmd_tvalid = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    for (int i = 0; i < 200 && rsp_n < target; i++) step();
    check("rsp_arrived", 64'(rsp_n), 64'(target));
  endtask

  int aw0, w0, b0, ar0, r0, n0, bad0;

  initial begin
    areset = 1'b1;
    s_axis_cmd_tdata = '0;
    s_axis_cmd_tuser = '0;
    s_axis_cmd_tvalid = 1'b0;
    m_axis_rsp_tready = 1'b1;
    repeat (3) @(posedge aclk);
    #2;
    check("reset_valids", 64'({s_axis_cmd_tready, m_axis_rsp_tvalid,
          m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
          m_axi_rready, busy, timeout_sticky}), 64'd0);
    check("reset_rsp", 64'({m_axis_rsp_tdata, m_axis_rsp_tuser}), 64'd0);
    areset = 1'b0;
    check("tready_rel0", 64'(s_axis_cmd_tready), 64'd0);
    step();
    check("tready_rel1", 64'(s_axis_cmd_tready), 64'd1);

    // zero-wait write
    aw0 = aw_n; w0 = w_n; b0 = b_n;
    sb.push_back('{data: 32'h0, user: 3'b000});
    send_cmd(32'h4, 32'hDEADBEEF, 1'b1, 4'hF);
    wait_rsp(1);
    check("wr_latency", 64'(rsp_rise - acc_cyc), 64'd3);
    check("wr_aw_cnt", 64'(aw_n - aw0), 64'd1);
    check("wr_w_cnt", 64'(w_n - w0), 64'd1);
    check("wr_b_cnt", 64'(b_n - b0), 64'd1);
    check("wr_addr", 64'(cap_awaddr), 64'h4);
    check("wr_data", 64'(cap_wdata), 64'hDEADBEEF);
    check("wr_strb", 64'(cap_wstrb), 64'hF);
    check("prot", 64'({m_axi_awprot, m_axi_arprot}), 64'd0);

    // read with 5 wait cycles on R
    slv_rdata = 32'h12345678; slv_rresp = 2'b00; r_delay = 5;
    bad0 = rdy_bad;
    sb.push_back('{data: 32'h12345678, user: 3'b000});
    send_cmd(32'h8, 32'h0, 1'b0, 4'hF);
    check("rd_busy", 64'(busy), 64'd1);
    wait_rsp(2);
    check("rd_latency", 64'(rsp_rise - acc_cyc), 64'd8);
    check("rd_addr", 64'(cap_araddr), 64'h8);
    check("rd_tready_low", 64'(rdy_bad - bad0), 64'd0);
    r_delay = 0;

    // W before AW
    aw_delay = 4;
    aw0 = aw_n; w0 = w_n; b0 = b_n;
    sb.push_back('{data: 32'h0, user: 3'b000});
    send_cmd(32'h10, 32'hA5A50F0F, 1'b1, 4'h3);
    step();
    check("w_first", 64'({m_axi_awvalid, m_axi_wvalid}), 64'b10);
    wait_rsp(3);
    check("wa_latency", 64'(rsp_rise - acc_cyc), 64'd7);
    check("wa_aw_cnt", 64'(aw_n - aw0), 64'd1);
    check("wa_w_cnt", 64'(w_n - w0), 64'd1);
    check("wa_b_cnt", 64'(b_n - b0), 64'd1);
    check("wa_strb", 64'(cap_wstrb), 64'h3);
    aw_delay = 0;

    // read error response
    slv_rdata = 32'hBAD0BAD0; slv_rresp = 2'b10;
    sb.push_back('{data: 32'hBAD0BAD0, user: 3'b010});
    send_cmd(32'h40, 32'h0, 1'b0, 4'h0);
    wait_rsp(4);
    check("slverr_sticky", 64'(timeout_sticky), 64'd0);

    // timeout on AR, late R drained
    slv_rdata = 32'hCAFEF00D; slv_rresp = 2'b00; ar_delay = 40;
    ar0 = ar_n; r0 = r_n;
    sb.push_back('{data: 32'h0, user: 3'b110});
    send_cmd(32'h100, 32'h0, 1'b0, 4'h0);
    wait_rsp(5);
    check("tmo_latency", 64'(rsp_rise - acc_cyc), 64'd17);
    check("tmo_sticky", 64'(timeout_sticky), 64'd1);
    check("tmo_arvalid", 64'(m_axi_arvalid), 64'd1);
    check("tmo_busy", 64'(busy), 64'd1);
    n0 = rsp_n;
    for (int i = 0; i < 200 && busy; i++) step();
    check("drain_busy", 64'(busy), 64'd0);
    check("drain_ar", 64'(ar_n - ar0), 64'd1);
    check("drain_r", 64'(r_n - r0), 64'd1);
    repeat (4) step();
    check("drain_no_rsp", 64'(rsp_n - n0), 64'd0);
    check("drain_sb", 64'(sb.size()), 64'd0);
    ar_delay = 0;

    // reset during WR_RESP
    b_delay = 100; m_axis_rsp_tready = 1'b0;
    sb.push_back('{data: 32'h0, user: 3'b000});
    send_cmd(32'h20, 32'h55, 1'b1, 4'hF);
    for (int i = 0; i < 20 && !m_axi_bready; i++) step();
    check("in_wr_resp", 64'(m_axi_bready), 64'd1);
    n0 = rsp_n;
    areset = 1'b1;
    #1;
    check("rst_mid", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready,
          m_axi_arvalid, m_axi_rready, m_axis_rsp_tvalid, busy}), 64'd0);
    check("rst_sticky", 64'(timeout_sticky), 64'd0);
    sb.delete();
    step();
    areset = 1'b0;
    b_delay = 0; m_axis_rsp_tready = 1'b1;
    sb.push_back('{data: 32'h0, user: 3'b000});
    send_cmd(32'h24, 32'h1, 1'b1, 4'h1);
    wait_rsp(n0 + 1);
    check("post_rst_lat", 64'(rsp_rise - acc_cyc), 64'd3);
    check("post_rst_addr", 64'(cap_awaddr), 64'h24);
    repeat (3) step();
    check("final_sb", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axil_cmd_manager.md
Name: axil_cmd_manager

Overview:
- AXI4-Lite manager (initiator) driven by a command stream; it is the initiator counterpart to our AXI4-Lite register subordinates.
- Accepts one read or write command per AXIS beat, performs a single AXI4-Lite transaction, and returns the response (read data or write status) on an AXIS response stream.
- Used by the in-fabric sequencer and the bench to program the ADC config, DMA and packetizer register banks without the PS.
- Strictly one transaction outstanding; includes a timeout watchdog.

Parameters:
- TIMEOUT_CYCLES, 1024, cycles from command accept to B/R handshake before a timeout response is issued; 0 disables the watchdog.
- AXI_PROT, 3'b000, constant value driven on m_axi_awprot and m_axi_arprot.

Ports:
- aclk  in  1  clock
- areset  in  1  asynchronous, active-high reset
- s_axis_cmd_tdata  in  64  [31:0] address, [63:32] write data
- s_axis_cmd_tuser  in  5  [4] write (1) / read (0), [3:0] wstrb
- s_axis_cmd_tvalid  in  1  command valid
- s_axis_cmd_tready  out  1  command ready
- m_axis_rsp_tdata  out  32  read data; 0 for writes
- m_axis_rsp_tuser  out  3  [2] timeout, [1:0] bresp/rresp
- m_axis_rsp_tvalid  out  1  response valid
- m_axis_rsp_tready  in  1  response ready
- m_axi_awaddr/awprot/awvalid/awready  out/out/out/in  32/3/1/1  write address channel
- m_axi_wdata/wstrb/wvalid/wready  out/out/out/in  32/4/1/1  write data channel
- m_axi_bresp/bvalid/bready  in/in/out  2/1/1  write response channel
- m_axi_araddr/arprot/arvalid/arready  out/out/out/in  32/3/1/1  read address channel
- m_axi_rdata/rresp/rvalid/rready  in/in/in/out  32/2/1/1  read data channel
- busy  out  1  high in every state except IDLE
- timeout_sticky  out  1  set on any timeout; cleared only by reset

Behaviour:
- Reset (async, areset=1): state=IDLE; all valid/ready outputs 0; rsp tdata/tuser 0; counters 0; timeout_sticky 0. Takes effect mid-transaction immediately; no response is produced for an interrupted command.
- s_axis_cmd_tready is registered: 1 only in IDLE, so at most one cycle after reset release or after a response handshake.
- States:
  - IDLE: on cmd handshake, latch addr/data/strb/dir and clear the watchdog. A write goes to WR_ADDR_DATA with awvalid=wvalid=1 from the next cycle. A read goes to RD_ADDR with arvalid=1.
  - WR_ADDR_DATA: awvalid and wvalid drop independently on their own handshakes, and may complete in the same cycle or in either order. When both are done, go to WR_RESP with bready=1.
  - WR_RESP: on bvalid&bready, capture bresp, set rsp tdata=0, bready=0, go to RESP.
  - RD_ADDR: on arready, arvalid=0, rready=1, go to RD_DATA.
  - RD_DATA: on rvalid&rready, capture rdata/rresp, rready=0, go to RESP.
  - RESP: m_axis_rsp_tvalid=1, holding data stable until rsp tready, then go to IDLE.
- Minimum latency with zero-wait subordinate: cmd accept at cycle 0, AXI address handshake at cycle 1, B/R at cycle 2, rsp_tvalid at cycle 3.
- Watchdog: counts every cycle in WR_ADDR_DATA, WR_RESP, RD_ADDR and RD_DATA. When the count equals TIMEOUT_CYCLES:
  - issue a response with tuser=3'b110 (timeout, SLVERR) and tdata=0, and set timeout_sticky;
  - continue to hold all pending AXI valids/readies, because AXI forbids withdrawing them;
  - on the late completion, discard the B/R and return to IDLE without issuing a second response.
  - This is implemented as a DRAIN state entered after the RESP handshake, or directly if the AXI side completes first.
- A B/R handshake and the timeout in the same cycle: the handshake wins and the response is normal.
- An unknown command tuser bit pattern cannot occur; the wstrb field is ignored for reads.
- Addresses are passed unmodified; no alignment check.

Decomposition:
- Shared package axil_pkg: state encoding, response codes (OKAY=2'b00, SLVERR=2'b10), tuser bit indices, command field offsets.
- One natural sub-module, axil_watchdog: counter with clear, enable and TIMEOUT_CYCLES compare, producing a single-cycle expire pulse.

Test Plan:
- Write 0xDEADBEEF to 0x04 with strb 4'hF, subordinate zero-wait → one AW and one W handshake; response tdata=0, tuser=3'b000; 3-cycle latency.
- Read 0x08 with subordinate returning 0x1234_5678 and rresp=00 after 5 wait cycles → rsp tdata=0x12345678, tuser=3'b000; cmd_tready stays low until the rsp handshake.
- Write where wready arrives 4 cycles before awready → wvalid drops first, awvalid is held, exactly one B is accepted, response OKAY.
- Read of unmapped 0x40 with subordinate rresp=10 → rsp tuser=3'b010; timeout_sticky=0.
- TIMEOUT_CYCLES=16, subordinate never asserts arready for 40 cycles → at cycle 16 rsp tuser=3'b110, timeout_sticky=1; arvalid stays high until the handshake; the late R is dropped and no second response is issued; busy falls after the R.
- areset pulsed while in WR_RESP with rsp_tready held low → all valids 0 in the same cycle, busy=0, no response emitted; the next command completes normally.
